field_serializer: RTL and testbench
===================================

Name: field_serializer

Overview:
- Reads a wide GF(2^m) field element out of the datapath as a stream of W-bit words over a VALID/READY handshake.
- It is the unload end of the operand path: the element is captured in parallel and leaves one word at a time, least significant word first.
- It sits between the field-register file outputs and the narrow host/bus interface that collects ECC results.

Parameters:
- N, 233, field element width in bits.
- W, 32, output word width in bits.
- Derived (local, not overridable): NW = ceil(N/W) (8 for the defaults); CW = clog2(NW), minimum 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLEAR  input  1  synchronous, active-high reset.
- START  input  1  request to capture DIN and begin streaming; honoured only in IDLE.
- DIN  input  N  field element to serialize; sampled only on an accepted START.
- DOUT  output  W  current output word.
- VALID  output  1  DOUT holds a valid word.
- READY  input  1  consumer accepts the word; a transfer occurs on an edge where VALID=1 and READY=1.
- LAST  output  1  the current word is word NW-1; qualified by VALID.
- BUSY  output  1  a transfer sequence is in progress.
- DONE  output  1  one-cycle pulse after the final word transfers.

Behaviour:
- Interface decision: one clock, CLK. Reset is CLEAR, synchronous and active-high.
- Reset: while CLEAR=1 at an edge, the block goes to IDLE and the next-cycle outputs are:
  - VALID=0, LAST=0, BUSY=0, DONE=0, DOUT=0.
  - Shadow register and word index cleared.
  - CLEAR has priority over START and READY in the same cycle.
  - CLEAR mid-stream aborts the stream: no further words and no DONE pulse.
- States: IDLE and SEND.
- IDLE:
  - On START=1, DIN is copied into an N-bit shadow register, the index is set to 0, and the state moves to SEND.
  - In the next cycle: VALID=1, BUSY=1, DOUT = word 0. Latency from START to the first VALID is one cycle.
  - Later changes on DIN do not affect the stream.
- SEND:
  - DOUT = word[idx], where word k = shadow[k*W+W-1 : k*W].
  - The final word is zero-padded above bit N-1. For the defaults, word 7 = {23'b0, DIN[232:224]}.
  - When VALID and READY are both 1 with idx < NW-1: idx increments and the next word appears the following cycle. One word per cycle is sustained while READY is held high.
  - When VALID and READY are both 1 with idx = NW-1: the state returns to IDLE. The next cycle has VALID=0, BUSY=0, LAST=0, and DONE=1 for exactly one cycle.
  - When READY=0: DOUT, LAST and idx hold stable and VALID stays 1. VALID never drops until its word transfers.
  - START in SEND is ignored and the shadow register is not overwritten.
- START in the DONE cycle (state is already IDLE) is accepted, so VALID returns the next cycle. This gives back-to-back streams with a gap of exactly one VALID-low cycle.
- LAST = VALID and (idx = NW-1). If NW=1, LAST is asserted together with the first VALID.
- Exact multiple (N mod W = 0): there is no padding and the final word is fully populated.
- DOUT is 0 whenever VALID=0, so there is no stale data on the bus.
- No combinational path from READY to VALID; READY only affects registered state.
- Synthesizable; all storage is flops reset by CLEAR. The shadow register may be cleared or left as is, but DOUT must read 0 while idle.

Test Plan:
- Streaming, defaults: DIN = 233-bit value with word k low byte = k, bit 232 = 1; START 1 cycle; READY=1 -> VALID high for exactly 8 consecutive cycles starting 1 cycle after START; DOUT = words 0..7 in order; word 7 = 0x00000100 | DIN[232:224]; LAST only on word 7; DONE pulse 1 cycle after word 7; BUSY low with DONE.
- Backpressure: READY toggled 1,0,0,1,0,1... -> each word repeated unchanged while READY=0; exactly 8 transfers, no skipped or duplicated words; DONE after the 8th accepted handshake only.
- START during SEND with a different DIN at word 3 -> ignored; remaining words come from the original DIN; no restart.
- CLEAR asserted while idx=4 with READY=1 -> next cycle VALID=0, BUSY=0, DONE=0, DOUT=0; a new START afterwards streams from word 0 of the new DIN.
- Back-to-back: START held high continuously, READY=1 -> two complete 8-word streams, one VALID-low cycle (the DONE cycle) between them; second stream carries the DIN sampled in the DONE cycle.
- Parameter variant N=64, W=32 -> 2 words, no padding, LAST on word 1; variant N=16, W=32 -> 1 word, zero-padded upper 16 bits, LAST with the first VALID.

Source files
------------

// File: rtl/field_serializer_if.sv
// Bus bundle between field_serializer and the host side that collects the
// serialized field element words.
interface field_serializer_if #(
    parameter int N = 233,
    parameter int W = 32
);
    // Handshake: a word transfers on a rising CLK edge where VALID=1 and READY=1.
    // VALID, DOUT and LAST hold until that transfer; READY never feeds VALID
    // combinationally, and DOUT reads zero whenever VALID is low.
    logic         START;
    logic [N-1:0] DIN;
    logic [W-1:0] DOUT;
    logic         VALID;
    logic         READY;
    logic         LAST;
    logic         BUSY;
    logic         DONE;
    logic         STATE_DBG;

    modport master (
        input  START,
        input  DIN,
        input  READY,
        output DOUT,
        output VALID,
        output LAST,
        output BUSY,
        output DONE,
        output STATE_DBG
    );

    modport slave (
        output START,
        output DIN,
        output READY,
        input  DOUT,
        input  VALID,
        input  LAST,
        input  BUSY,
        input  DONE,
        input  STATE_DBG
    );
endinterface

// File: rtl/field_serializer.sv
// Captures an N-bit GF(2^m) element in one cycle and streams it out as
// W-bit words, least significant word first, over a VALID/READY handshake.
module field_serializer #(
    parameter int N = 233,
    parameter int W = 32
) (
    input  logic                 CLK,
    input  logic                 CLEAR,
    field_serializer_if.master   bus
);
    localparam int NW = (N + W - 1) / W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    // Shadow depth rounded up to a power of two so idx never indexes past it.
    localparam int NS = 2 ** CW;
    localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   idx_q;
    logic [CW-1:0]   idx_d;
    logic            capture;
    logic            done_d;
    logic            done_q;
    logic [W-1:0]    shadow [NS];
    logic [NS*W-1:0] din_ext;

    // Zero above bit N-1 so the final word comes out padded.
    always_comb begin
        din_ext        = '0;
        din_ext[N-1:0] = bus.DIN;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.READY) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (capture) begin
                for (int k = 0; k < NS; k++) begin
                    shadow[k] <= din_ext[k*W +: W];
                end
            end
        end
    end

    assign bus.VALID     = (state_q == SEND);
    assign bus.BUSY      = (state_q == SEND);
    assign bus.LAST      = (state_q == SEND) && (idx_q == LAST_IDX);
    assign bus.DOUT      = (state_q == SEND) ? shadow[idx_q] : '0;
    assign bus.DONE      = done_q;
    assign bus.STATE_DBG = (state_q == SEND);
endmodule

// File: tb/tb_field_serializer.sv
// Directed bench for field_serializer: default 233/32 instance plus the
// 64/32 and 16/32 variants, checked through expected-word queues.
module tb_field_serializer;
    logic clk = 1'b0;
    logic clear;
    bit   mon_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;

    logic [32:0] exp_q[$];
    logic [32:0] exp64_q[$];
    logic [32:0] exp16_q[$];

    field_serializer_if #(.N(233), .W(32)) u_if ();
    field_serializer_if #(.N(64),  .W(32)) u_if64 ();
    field_serializer_if #(.N(16),  .W(32)) u_if16 ();

    field_serializer #(.N(233), .W(32)) u_dut (
        .CLK(clk), .CLEAR(clear), .bus(u_if.master)
    );
    field_serializer #(.N(64), .W(32)) u_dut64 (
        .CLK(clk), .CLEAR(clear), .bus(u_if64.master)
    );
    field_serializer #(.N(16), .W(32)) u_dut16 (
        .CLK(clk), .CLEAR(clear), .bus(u_if16.master)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] tag, input logic [8:0] top, input int k);
        if (k == 7) return {23'b0, top};
        return {tag, 8'h30 + 8'(k), 8'h5C, 8'(k)};
    endfunction

    function automatic logic [232:0] make_din(input logic [7:0] tag, input logic [8:0] top);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 7; k++) v[k*32 +: 32] = exp_word(tag, top, k);
        v[224 +: 9] = top;
        return v[232:0];
    endfunction

    task automatic push_stream(input logic [7:0] tag, input logic [8:0] top);
        for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), exp_word(tag, top, k)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_stream(input logic [7:0] tag, input logic [8:0] top);
        u_if.START = 1'b1;
        u_if.DIN   = make_din(tag, top);
        push_stream(tag, top);
        tick();
        u_if.START = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (u_if.DONE) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1'b1);
    endtask

    // ---------------- monitor / scoreboard (default instance) ----------------
    logic        prev_final = 1'b0;
    logic        prev_hold  = 1'b0;
    logic [31:0] prev_dout  = '0;
    logic        prev_last  = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic [32:0] e;
            check("done_timing", u_if.DONE, prev_final);
            check("busy_vs_valid", u_if.BUSY, u_if.VALID);
            if (!u_if.VALID) begin
                check("dout_idle_zero", u_if.DOUT, 32'h0);
                check("last_idle_zero", u_if.LAST, 1'b0);
            end
            if (prev_hold) begin
                check("hold_valid", u_if.VALID, 1'b1);
                check("hold_dout", u_if.DOUT, prev_dout);
                check("hold_last", u_if.LAST, prev_last);
            end
            if (u_if.VALID && u_if.READY && !clear) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {u_if.LAST, u_if.DOUT}, 33'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {u_if.LAST, u_if.DOUT}, e);
                end
            end
            prev_final = u_if.VALID && u_if.READY && u_if.LAST && !clear;
            prev_hold  = u_if.VALID && !u_if.READY && !clear;
            prev_dout  = u_if.DOUT;
            prev_last  = u_if.LAST;
        end
    end

    // ---------------- monitors for the parameter variants ----------------
    always @(negedge clk) begin
        if (mon_en && u_if64.VALID && u_if64.READY && !clear) begin
            if (exp64_q.size() == 0)
                check("v64_unexpected", {u_if64.LAST, u_if64.DOUT}, 33'h0);
            else
                check("v64_word", {u_if64.LAST, u_if64.DOUT}, exp64_q.pop_front());
        end
        if (mon_en && u_if16.VALID && u_if16.READY && !clear) begin
            if (exp16_q.size() == 0)
                check("v16_unexpected", {u_if16.LAST, u_if16.DOUT}, 33'h0);
            else
                check("v16_word", {u_if16.LAST, u_if16.DOUT}, exp16_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] vseq;
        logic [9:0] dseq;
        logic [5:0] pat;
        bit         seen;

        clear        = 1'b1;
        u_if.START   = 1'b0;  u_if.DIN   = '0; u_if.READY   = 1'b0;
        u_if64.START = 1'b0;  u_if64.DIN = '0; u_if64.READY = 1'b1;
        u_if16.START = 1'b0;  u_if16.DIN = '0; u_if16.READY = 1'b1;
        repeat (3) tick();
        check("rst_valid", u_if.VALID, 1'b0);
        check("rst_busy",  u_if.BUSY,  1'b0);
        check("rst_done",  u_if.DONE,  1'b0);
        check("rst_last",  u_if.LAST,  1'b0);
        check("rst_dout",  u_if.DOUT,  32'h0);
        check("rst_state", u_if.STATE_DBG, 1'b0);
        clear  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Streaming with READY held high: 8 VALID cycles, then DONE.
        u_if.READY = 1'b1;
        start_stream(8'hA1, 9'h107);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check("t1_first_word", u_if.DOUT, 32'hA1305C00);
            if (i == 7) check("t1_last_word", {u_if.LAST, u_if.DOUT}, 33'h1_0000_0107);
            vseq[i] = u_if.VALID;
            dseq[i] = u_if.DONE;
        end
        check("t1_valid_seq", vseq, 10'b00_1111_1111);
        check("t1_done_seq",  dseq, 10'b01_0000_0000);
        check("t1_q_empty", exp_q.size(), 0);

        // Backpressure pattern 1,0,0,1,0,1 repeating.
        tick();
        u_if.READY = 1'b0;
        xfer_cnt   = 0;
        pat        = 6'b101001;
        start_stream(8'hC3, 9'h0E7);
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            u_if.READY = pat[c % 6];
            tick();
            if (u_if.DONE) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_done_seen", seen, 1'b1);
        check("bp_xfer_cnt", xfer_cnt, 8);
        check("bp_q_empty", exp_q.size(), 0);

        // START with new DIN while word 3 is on the bus is ignored.
        u_if.READY = 1'b1;
        tick();
        start_stream(8'h5E, 9'h1AB);
        repeat (3) tick();
        check("ss_word3_present", u_if.DOUT, 32'h5E335C03);
        u_if.START = 1'b1;
        u_if.DIN   = make_din(8'h77, 9'h011);
        tick();
        u_if.START = 1'b0;
        wait_done("ss_done_seen");
        repeat (2) tick();
        check("ss_no_restart", u_if.VALID, 1'b0);
        check("ss_q_empty", exp_q.size(), 0);

        // CLEAR while idx=4 aborts the stream.
        start_stream(8'h9D, 9'h0F0);
        repeat (4) tick();
        check("clr_word4_present", u_if.DOUT, 32'h9D345C04);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        check("clr_valid", u_if.VALID, 1'b0);
        check("clr_busy",  u_if.BUSY,  1'b0);
        check("clr_done",  u_if.DONE,  1'b0);
        check("clr_dout",  u_if.DOUT,  32'h0);
        tick();
        check("clr_no_done", u_if.DONE, 1'b0);
        start_stream(8'hE4, 9'h155);
        check("clr_restart_word0", u_if.DOUT, 32'hE4305C00);
        wait_done("clr_done_seen");
        check("clr_q_empty", exp_q.size(), 0);

        // Back-to-back with START held high.
        tick();
        u_if.START = 1'b1;
        u_if.DIN   = make_din(8'h4A, 9'h1C2);
        push_stream(8'h4A, 9'h1C2);
        tick();
        u_if.DIN = make_din(8'hB2, 9'h033);
        push_stream(8'hB2, 9'h033);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (u_if.DONE) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b_done1_seen", seen, 1'b1);
        check("b2b_gap_valid_low", u_if.VALID, 1'b0);
        tick();
        u_if.START = 1'b0;
        check("b2b_second_valid", u_if.VALID, 1'b1);
        check("b2b_second_word0", u_if.DOUT, 32'hB2305C00);
        wait_done("b2b_done2_seen");
        check("b2b_q_empty", exp_q.size(), 0);

        // Parameter variants: 64/32 (two words) and 16/32 (one padded word).
        tick();
        exp64_q.push_back({1'b0, 32'h89AB_CDEF});
        exp64_q.push_back({1'b1, 32'h0123_4567});
        exp16_q.push_back({1'b1, 32'h0000_BEEF});
        u_if64.START = 1'b1;  u_if64.DIN = 64'h0123_4567_89AB_CDEF;
        u_if16.START = 1'b1;  u_if16.DIN = 16'hBEEF;
        tick();
        u_if64.START = 1'b0;
        u_if16.START = 1'b0;
        check("v16_last_first", u_if16.LAST, 1'b1);
        check("v64_last_word0", u_if64.LAST, 1'b0);
        tick();
        check("v16_done", u_if16.DONE, 1'b1);
        check("v64_last_word1", u_if64.LAST, 1'b1);
        tick();
        check("v64_done", u_if64.DONE, 1'b1);
        check("v64_valid_off", u_if64.VALID, 1'b0);
        check("v64_q_empty", exp64_q.size(), 0);
        check("v16_q_empty", exp16_q.size(), 0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
